// File: rtl/spram_be_clr_if.sv
// Client bus for spram_be_clr: address, write data/enables, flush request,
// read data and the ready flag that gates all access.
interface spram_be_clr_if #(
  parameter int unsigned DATABITS = 32,
  parameter int unsigned ADDRBITS = 5
) ();

  logic [ADDRBITS-1:0]   addr;
  logic [DATABITS-1:0]   data_in;
  logic [DATABITS/8-1:0] be;
  logic                  we;
  logic                  flush;
  logic [DATABITS-1:0]   data_out;
  logic                  ready;

  // Client side drives requests and observes data/ready.
  modport master (
    output addr, data_in, be, we, flush,
    input  data_out, ready
  );

  // RAM side.
  modport slave (
    input  addr, data_in, be, we, flush,
    output data_out, ready
  );

endinterface

// File: rtl/spram_be_clr.sv
// Single-port RAM with byte-lane writes, optional registered read and a
// built-in clear engine that sweeps CLRVAL into every word after reset and
// on each flush. Client access is only honoured while ready is high.
module spram_be_clr #(
  parameter int unsigned          DATABITS = 32,
  parameter int unsigned          ADDRBITS = 5,
  parameter int unsigned          REGOUT   = 0,
  parameter logic [DATABITS-1:0]  CLRVAL   = '0
) (
  input  logic           clk,
  input  logic           reset_n,
  spram_be_clr_if.slave  bus
);

  localparam int unsigned MEMSIZE = 2 ** ADDRBITS;
  localparam int unsigned NBYTES  = DATABITS / 8;

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e              state_q, state_d;
  logic [ADDRBITS-1:0] clr_cnt_q, clr_cnt_d;
  logic                clr_we;
  logic                wr_en;

  // The array is deliberately not reset; the clear sweep initialises it.
  logic [DATABITS-1:0] mem_q [MEMSIZE];

  // FSM and clear-counter state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic: sweep every word, flush restarts the sweep from word 0.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      StClear: begin
        clr_we = 1'b1;
        if (bus.flush) begin
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (&clr_cnt_q) begin
            state_d = StIdle;
          end
        end
      end
      StIdle: begin
        if (bus.flush) begin
          // Flush wins over a coincident write.
          state_d   = StClear;
          clr_cnt_d = '0;
        end else begin
          wr_en = bus.we;
        end
      end
      default: begin
        state_d   = StClear;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign bus.ready = (state_q == StIdle);

  // Array write port: clear sweep or byte-lane client write.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= CLRVAL;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (bus.be[i]) begin
          mem_q[bus.addr][8*i +: 8] <= bus.data_in[8*i +: 8];
        end
      end
    end
  end

  if (REGOUT != 0) begin : g_regout
    logic [DATABITS-1:0] dout_q;

    // Registered read-first port; holds its value while not ready.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dout_q <= '0;
      end else if (bus.ready) begin
        dout_q <= mem_q[bus.addr];
      end
    end

    assign bus.data_out = dout_q;
  end else begin : g_combout
    assign bus.data_out = mem_q[bus.addr];
  end

endmodule

// File: tb/tb_spram_be_clr.sv
// Bench for spram_be_clr: two instances (combinational read with CLRVAL=0,
// registered read with CLRVAL=0x5A5A5A5A) share one randomized stimulus
// stream. A behavioural model predicts each cycle's outputs into a queue;
// an independent monitor pops and compares.
module tb_spram_be_clr;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NW   = 32;
  localparam logic [31:0] CLR0 = 32'h0000_0000;
  localparam logic [31:0] CLR1 = 32'h5A5A_5A5A;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  spram_be_clr_if #(.DATABITS(DW), .ADDRBITS(AW)) bus0 ();
  spram_be_clr_if #(.DATABITS(DW), .ADDRBITS(AW)) bus1 ();

  spram_be_clr #(
    .DATABITS(DW), .ADDRBITS(AW), .REGOUT(0), .CLRVAL(CLR0)
  ) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  spram_be_clr #(
    .DATABITS(DW), .ADDRBITS(AW), .REGOUT(1), .CLRVAL(CLR1)
  ) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  typedef struct {
    logic        rdy;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: word contents, cycles of clearing left, read register.
  logic [31:0] m0 [NW];
  logic [31:0] m1 [NW];
  int          clr_left;
  logic [31:0] r1;

  task automatic model_clear();
    for (int i = 0; i < NW; i++) begin
      m0[i] = CLR0;
      m1[i] = CLR1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, queue expected outputs, step model.
  task automatic cycle(input logic rst_v, input logic we_v, input logic fl_v,
                       input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    exp_t e;
    @(negedge clk);
    reset_n      = rst_v;
    bus0.we      = we_v;   bus1.we      = we_v;
    bus0.flush   = fl_v;   bus1.flush   = fl_v;
    bus0.addr    = a;      bus1.addr    = a;
    bus0.data_in = d;      bus1.data_in = d;
    bus0.be      = b;      bus1.be      = b;
    if (!rst_v) begin
      clr_left = NW;
      r1       = '0;
      model_clear();
    end
    e.rdy = (clr_left == 0);
    e.d0  = m0[a];
    e.d1  = r1;
    q.push_back(e);
    if (rst_v) begin
      if (clr_left == 0) begin
        r1 = m1[a];
        if (fl_v) begin
          clr_left = NW;
          model_clear();
        end else if (we_v) begin
          for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
              m0[a][8*i +: 8] = d[8*i +: 8];
              m1[a][8*i +: 8] = d[8*i +: 8];
            end
          end
        end
      end else if (fl_v) begin
        clr_left = NW;
      end else begin
        clr_left--;
      end
    end
  endtask

  task automatic rnd_cycle(input logic we_v);
    cycle(1'b1, we_v, 1'b0, 5'($urandom), $urandom, 4'($urandom));
  endtask

  task automatic read_all();
    for (int i = 0; i < NW; i++) cycle(1'b1, 1'b0, 1'b0, 5'(i), 32'h0, 4'h0);
  endtask

  // Monitor: compare DUT outputs against the queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ready_comb", {31'h0, bus0.ready}, {31'h0, e.rdy});
        check("ready_reg",  {31'h0, bus1.ready}, {31'h0, e.rdy});
        if (e.rdy) check("data_comb", bus0.data_out, e.d0);
        check("data_reg", bus1.data_out, e.d1);
      end
    end
  end

  initial begin
    bus0.we = 1'b0; bus0.flush = 1'b0; bus0.addr = '0; bus0.data_in = '0; bus0.be = '0;
    bus1.we = 1'b0; bus1.flush = 1'b0; bus1.addr = '0; bus1.data_in = '0; bus1.be = '0;
    clr_left = NW;
    r1       = '0;
    model_clear();

    // Reset, then the initial sweep with writes attempted while not ready.
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 4'h0);
    repeat (36) rnd_cycle(1'b1);
    read_all();

    // Byte-lane merge at addr 3.
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'hAABB_CCDD, 4'b1111);
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'h1122_3344, 4'b0101);
    cycle(1'b1, 1'b0, 1'b0, 5'd3, 32'h0, 4'h0);
    cycle(1'b1, 1'b1, 1'b0, 5'd9, 32'hFFFF_FFFF, 4'b0000);
    cycle(1'b1, 1'b0, 1'b0, 5'd9, 32'h0, 4'h0);

    // Read-during-write at addr 7.
    cycle(1'b1, 1'b1, 1'b0, 5'd7, 32'h1234_5678, 4'hF);
    cycle(1'b1, 1'b1, 1'b0, 5'd7, 32'hDEAD_BEEF, 4'hF);
    cycle(1'b1, 1'b0, 1'b0, 5'd7, 32'h0, 4'h0);
    cycle(1'b1, 1'b0, 1'b0, 5'd7, 32'h0, 4'h0);

    // Fill with ones, flush with a coincident write to addr 5.
    for (int i = 0; i < NW; i++) cycle(1'b1, 1'b1, 1'b0, 5'(i), 32'hFFFF_FFFF, 4'hF);
    cycle(1'b1, 1'b1, 1'b1, 5'd5, 32'hCAFE_F00D, 4'hF);
    repeat (34) rnd_cycle(1'b1);
    read_all();

    // Flush again partway through a clear sweep.
    for (int i = 0; i < NW; i++) cycle(1'b1, 1'b1, 1'b0, 5'(i), $urandom, 4'hF);
    cycle(1'b1, 1'b0, 1'b1, 5'd0, 32'h0, 4'h0);
    repeat (19) rnd_cycle(1'b1);
    cycle(1'b1, 1'b0, 1'b1, 5'd0, 32'h0, 4'h0);
    repeat (34) rnd_cycle(1'b1);
    read_all();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(1'b1, 1'($urandom), ($urandom_range(39) == 0), 5'($urandom), $urandom,
            4'($urandom));
    end

    // Reset pulse in the middle of a write burst.
    repeat (6) rnd_cycle(1'b1);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 5'($urandom), $urandom, 4'hF);
    repeat (34) rnd_cycle(1'b1);
    read_all();
    repeat (100) rnd_cycle(1'($urandom));
    read_all();

    @(negedge clk);
    #5;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spram_be_clr.md
Name: spram_be_clr

Overview:
Parametrised single-port RAM for the icache data/tag arrays. Successor to the fixed 32x32 array, with configurable width and depth, byte-lane write enables, and optional registered read output. Adds a built-in clear engine that writes CLRVAL to every word after reset and on each flush request, so cache invalidation needs no external sweep logic. The ready output gates all client access.

Parameters:
DATABITS, 32, word width in bits; must be a multiple of 8
ADDRBITS, 5, address width; MEMSIZE = 2**ADDRBITS words
REGOUT, 0, 0 = combinational read (data_out follows addr); 1 = registered read with 1-cycle latency
CLRVAL, 0, DATABITS-wide value written to every word during clear

Ports:
clk  input  1  clock; all state changes on the rising edge
reset_n  input  1  asynchronous active-low reset
addr  input  ADDRBITS  word address for read and write
data_in  input  DATABITS  write data
be  input  DATABITS/8  byte-lane write enables; bit i covers data bits [8i+7:8i]
we  input  1  write strobe
flush  input  1  single-cycle request to re-clear the whole array
data_out  output  DATABITS  read data
ready  output  1  high when the array is idle and accepts reads and writes

Behaviour:
- FSM states: CLEAR, IDLE. Clear counter clr_cnt is ADDRBITS wide.
- reset_n low, asynchronously:
  - state=CLEAR, clr_cnt=0, ready=0.
  - data_out register = 0 (REGOUT=1).
  - The array itself is not reset.
- CLEAR:
  - Each cycle: memblock[clr_cnt] <= CLRVAL, then clr_cnt++.
  - When clr_cnt == MEMSIZE-1 the write completes and the next state is IDLE.
  - ready rises in the cycle after the last clear write, i.e. ready=1 exactly MEMSIZE cycles after the first clk edge with reset_n high.
- IDLE:
  - ready=1.
  - Write: if we=1, each byte lane i with be[i]=1 is written from data_in; lanes with be[i]=0 keep their value. we with be=0 writes nothing.
- flush:
  - In IDLE: next state is CLEAR with clr_cnt=0; ready=0 from the next cycle.
  - In CLEAR: clr_cnt restarts at 0, so a full MEMSIZE sweep follows.
  - flush and we in the same IDLE cycle: flush wins and the write is dropped.
- ready=0:
  - we and be are ignored; no client write may corrupt the array.
  - REGOUT=0: data_out = memblock[addr] combinationally; valid only when ready=1.
  - REGOUT=1: data_out register holds its last value.
- Read, REGOUT=0: data_out = memblock[addr] combinationally; a write shows on data_out after the clock edge.
- Read, REGOUT=1:
  - data_out <= memblock[addr] on each edge while ready=1.
  - Read-during-write to the same address returns OLD data (read-first); the new data appears on the following read.
- reset_n asserted mid-clear or mid-write: the FSM restarts clear from word 0 on release. Any partial write is overwritten by the sweep.
- Address range: ADDRBITS covers exactly MEMSIZE words, so there is no out-of-range case. clr_cnt wraps naturally but is never used past MEMSIZE-1.

Test Plan:
- Reset, defaults (ADDRBITS=5, CLRVAL=0): release reset_n, first hold memory at 0xFFFFFFFF via backdoor -> ready stays 0 for 32 cycles, rises on cycle 32; reads of addr 0..31 all return 0x00000000.
- Byte-enable write, REGOUT=0: write 0xAABBCCDD with be=4'b1111 to addr 3, then 0x11223344 with be=4'b0101 -> data_out at addr 3 = 0xAA22CC44.
- Registered read, REGOUT=1: addr 7 holds 0x12345678; write 0xDEADBEEF to addr 7 while reading addr 7 -> data_out=0x12345678 after that edge, 0xDEADBEEF after the next.
- Flush in IDLE with a simultaneous we to addr 5 -> ready=0 next cycle for 32 cycles; addr 5 reads CLRVAL; the write is lost.
- Flush at clear cycle 20 -> ready rises 32 cycles after the flush edge, not 12; writes attempted while ready=0 leave all words at CLRVAL.
- reset_n pulse during an IDLE write burst, with CLRVAL=0x5A5A5A5A parameterised -> ready=0 asynchronously; after release, full 32-cycle clear; all words read 0x5A5A5A5A; data_out register reads 0 before the first post-ready read.
